// File: rtl/vector_operand_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vector_operand_fetch
// Function : Sequential operand-read stage of the vector lane. Accepts one
//            issued instruction, reads v0 / vs1 / vs2 / vd through the single
//            synchronous register-file read port and presents the assembled
//            operand bundle on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module vector_operand_fetch #(
  parameter int DATA_WIDTH     = 64,
  parameter int TAG_WIDTH      = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  // issue side
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] issue_vs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_vs2,
  input  logic [REG_ADDR_WIDTH-1:0] issue_vd,
  input  logic                      issue_vm,
  input  logic [TAG_WIDTH-1:0]      issue_tag,
  // register-file read port
  output logic                      rf_read_enable,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  // operand bundle
  output logic                      operand_valid,
  input  logic                      operand_ready,
  output logic [DATA_WIDTH-1:0]     v0_data,
  output logic [DATA_WIDTH-1:0]     vs1_data,
  output logic [DATA_WIDTH-1:0]     vs2_data,
  output logic [DATA_WIDTH-1:0]     vd_old_data,
  output logic [TAG_WIDTH-1:0]      operand_tag,
  output logic [REG_ADDR_WIDTH-1:0] operand_vd,
  output logic                      operand_vm
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ_V0  = 3'd1,
    READ_VS1 = 3'd2,
    READ_VS2 = 3'd3,
    READ_VD  = 3'd4,
    DRAIN    = 3'd5,
    VALID    = 3'd6
  } state_t;

  // Which operand register the read issued last cycle will land in.
  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_V0   = 3'd1,
    DST_VS1  = 3'd2,
    DST_VS2  = 3'd3,
    DST_VD   = 3'd4
  } dst_t;

  state_t state_q, state_d;
  dst_t   dst_q, dst_d;
  logic   accept;

  logic [REG_ADDR_WIDTH-1:0] vs1_idx_q;
  logic [REG_ADDR_WIDTH-1:0] vs2_idx_q;
  logic [REG_ADDR_WIDTH-1:0] vd_idx_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic                      vm_q;

  logic [DATA_WIDTH-1:0] v0_q;
  logic [DATA_WIDTH-1:0] vs1_q;
  logic [DATA_WIDTH-1:0] vs2_q;
  logic [DATA_WIDTH-1:0] vd_old_q;

  // Handshake flags come from state alone so nothing from issue_valid or
  // operand_ready reaches an output combinationally.
  assign issue_ready   = (state_q == IDLE);
  assign operand_valid = (state_q == VALID);

  // Next-state, read-port drive and capture-destination decode.
  always_comb begin
    state_d         = state_q;
    dst_d           = DST_NONE;
    accept          = 1'b0;
    rf_read_enable  = 1'b0;
    rf_read_address = '0;
    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          accept  = 1'b1;
          state_d = issue_vm ? READ_VS1 : READ_V0;
        end
      end
      READ_V0: begin
        rf_read_enable  = 1'b1;
        rf_read_address = '0;
        dst_d           = DST_V0;
        state_d         = READ_VS1;
      end
      READ_VS1: begin
        rf_read_enable  = 1'b1;
        rf_read_address = vs1_idx_q;
        dst_d           = DST_VS1;
        state_d         = READ_VS2;
      end
      READ_VS2: begin
        rf_read_enable  = 1'b1;
        rf_read_address = vs2_idx_q;
        dst_d           = DST_VS2;
        state_d         = READ_VD;
      end
      READ_VD: begin
        rf_read_enable  = 1'b1;
        rf_read_address = vd_idx_q;
        dst_d           = DST_VD;
        state_d         = DRAIN;
      end
      DRAIN: begin
        state_d = VALID;
      end
      VALID: begin
        if (operand_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture-destination registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dst_q   <= DST_NONE;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
    end
  end

  // Issue latch: register indices, tag and mask control captured at accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs1_idx_q <= '0;
      vs2_idx_q <= '0;
      vd_idx_q  <= '0;
      tag_q     <= '0;
      vm_q      <= 1'b0;
    end else if (accept) begin
      vs1_idx_q <= issue_vs1;
      vs2_idx_q <= issue_vs2;
      vd_idx_q  <= issue_vd;
      tag_q     <= issue_tag;
      vm_q      <= issue_vm;
    end
  end

  // Operand registers: read data lands one cycle after its read strobe;
  // an unmasked op gets an all-ones v0 at accept instead of a v0 read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v0_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_old_q <= '0;
    end else begin
      if (accept && issue_vm) begin
        v0_q <= '1;
      end
      case (dst_q)
        DST_V0:  v0_q     <= rf_read_data;
        DST_VS1: vs1_q    <= rf_read_data;
        DST_VS2: vs2_q    <= rf_read_data;
        DST_VD:  vd_old_q <= rf_read_data;
        default: ;
      endcase
    end
  end

  assign v0_data     = v0_q;
  assign vs1_data    = vs1_q;
  assign vs2_data    = vs2_q;
  assign vd_old_data = vd_old_q;
  assign operand_tag = tag_q;
  assign operand_vd  = vd_idx_q;
  assign operand_vm  = vm_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_operand_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vector_operand_fetch
// Function : Scoreboard bench for vector_operand_fetch. The driver pushes the
//            expected transaction (read list, latency, bundle) at accept; a
//            negedge monitor checks handshake flags, read port and bundle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_operand_fetch;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_vs1, issue_vs2, issue_vd;
  logic        issue_vm;
  logic [7:0]  issue_tag;
  logic        rf_read_enable;
  logic [4:0]  rf_read_address;
  logic [63:0] rf_read_data;
  logic        operand_valid;
  logic        operand_ready;
  logic [63:0] v0_data, vs1_data, vs2_data, vd_old_data;
  logic [7:0]  operand_tag;
  logic [4:0]  operand_vd;
  logic        operand_vm;

  vector_operand_fetch #(
    .DATA_WIDTH(64), .TAG_WIDTH(8), .REG_ADDR_WIDTH(5)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd),
    .issue_vm(issue_vm), .issue_tag(issue_tag),
    .rf_read_enable(rf_read_enable), .rf_read_address(rf_read_address),
    .rf_read_data(rf_read_data),
    .operand_valid(operand_valid), .operand_ready(operand_ready),
    .v0_data(v0_data), .vs1_data(vs1_data), .vs2_data(vs2_data),
    .vd_old_data(vd_old_data), .operand_tag(operand_tag),
    .operand_vd(operand_vd), .operand_vm(operand_vm)
  );

  // Expected transaction: reads in issue order, cycles from accept to VALID,
  // and the bundle the stage must present.
  typedef struct {
    int          acc;
    int          lat;
    int          nrd;
    logic [3:0][4:0] addrs;
    logic [63:0] v0, vs1, vs2, vd_old;
    logic [7:0]  tag;
    logic [4:0]  vd;
    logic        vm;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem [32];
  int          cyc;
  int          total;
  int          passed;
  int          ready_mode;   // 0 random, 1 hold low, 2 hold high

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Register file: data one cycle after the strobe, garbage otherwise.
  always @(posedge clock) begin
    if (rf_read_enable) rf_read_data <= mem[rf_read_address];
    else                rf_read_data <= {$urandom, $urandom};
  end

  // Downstream ready, driven 2 ns after each rising edge.
  initial begin
    operand_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       operand_ready = ($urandom_range(0, 3) != 0);
        1:       operand_ready = 1'b0;
        default: operand_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic exp_t mk(input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic vm,
                              input logic [7:0] tag, input int acc);
    exp_t e;
    e.acc = acc;
    e.lat = vm ? 5 : 6;
    e.nrd = vm ? 3 : 4;
    if (vm) begin
      e.addrs[0] = s1; e.addrs[1] = s2; e.addrs[2] = d; e.addrs[3] = 5'd0;
    end else begin
      e.addrs[0] = 5'd0; e.addrs[1] = s1; e.addrs[2] = s2; e.addrs[3] = d;
    end
    e.v0     = vm ? 64'hFFFF_FFFF_FFFF_FFFF : mem[0];
    e.vs1    = mem[s1];
    e.vs2    = mem[s2];
    e.vd_old = mem[d];
    e.tag    = tag;
    e.vd     = d;
    e.vm     = vm;
    return e;
  endfunction

  // Called 1 ns after a rising edge. Holds issue_valid until the model says
  // the stage is free, records the accept, and returns 1 ns after that edge.
  task automatic do_issue(input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic vm, input logic [7:0] tag);
    int w;
    w = 0;
    issue_valid = 1'b1;
    issue_vs1 = s1; issue_vs2 = s2; issue_vd = d; issue_vm = vm; issue_tag = tag;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clock); #1; w++;
    end
    if (w >= 300) begin
      chk("issue_wait_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
    exp_q.push_back(mk(s1, s2, d, vm, tag, cyc));
    @(posedge clock); #1;
    issue_valid = 1'b0;
    issue_vs1 = 5'($urandom); issue_vs2 = 5'($urandom); issue_vd = 5'($urandom);
    issue_vm = 1'($urandom); issue_tag = 8'($urandom);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clock); #1; w++;
    end
    if (w >= 300) begin
      chk("drain_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_operand_valid", 64'(operand_valid), 64'd0);
    chk("rst_rf_en", 64'(rf_read_enable), 64'd0);
    chk("rst_rf_addr", 64'(rf_read_address), 64'd0);
    chk("rst_v0", v0_data, 64'd0);
    chk("rst_vs1", vs1_data, 64'd0);
    chk("rst_vs2", vs2_data, 64'd0);
    chk("rst_vd_old", vd_old_data, 64'd0);
    chk("rst_tag", 64'(operand_tag), 64'd0);
    chk("rst_vd", 64'(operand_vd), 64'd0);
    chk("rst_vm", 64'(operand_vm), 64'd0);
  endtask

  // Monitor: compares the DUT against the oldest outstanding transaction.
  logic       m_have, m_ready, m_en, m_valid;
  logic [4:0] m_addr;
  int         m_k;
  exp_t       m_e;
  always @(negedge clock) begin
    if (reset_n) begin
      m_have = (exp_q.size() != 0);
      m_k = 0;
      if (m_have) begin
        m_e = exp_q[0];
        m_k = cyc - m_e.acc;
      end
      m_ready = !(m_have && m_k > 0);
      m_en    = m_have && m_k >= 1 && m_k <= m_e.nrd;
      m_addr  = 5'd0;
      if (m_en) m_addr = m_e.addrs[m_k-1];
      m_valid = m_have && m_k >= m_e.lat;
      chk("issue_ready", 64'(issue_ready), 64'(m_ready));
      chk("operand_valid", 64'(operand_valid), 64'(m_valid));
      chk("rf_read_enable", 64'(rf_read_enable), 64'(m_en));
      chk("rf_read_address", 64'(rf_read_address), 64'(m_addr));
      if (m_valid) begin
        chk("v0_data", v0_data, m_e.v0);
        chk("vs1_data", vs1_data, m_e.vs1);
        chk("vs2_data", vs2_data, m_e.vs2);
        chk("vd_old_data", vd_old_data, m_e.vd_old);
        chk("operand_tag", 64'(operand_tag), 64'(m_e.tag));
        chk("operand_vd", 64'(operand_vd), 64'(m_e.vd));
        chk("operand_vm", 64'(operand_vm), 64'(m_e.vm));
        if (operand_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    total++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    total = 0; passed = 0; cyc = 0; ready_mode = 2;
    reset_n = 1'b0; issue_valid = 1'b0;
    issue_vs1 = '0; issue_vs2 = '0; issue_vd = '0; issue_vm = 1'b0; issue_tag = '0;
    for (int i = 0; i < 32; i++) mem[i] = 64'h1000_0000_0000_0000 | 64'(i);
    #3;
    chk_reset_vals();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // masked and unmasked fetch of the same operands
    do_issue(5'd3, 5'd4, 5'd5, 1'b0, 8'hA5);
    wait_drain();
    do_issue(5'd3, 5'd4, 5'd5, 1'b1, 8'hA5);
    wait_drain();

    // back-pressure: ready low well past VALID while the next issue waits
    ready_mode = 1;
    do_issue(5'd10, 5'd11, 5'd12, 1'b0, 8'h3C);
    fork
      do_issue(5'd13, 5'd14, 5'd15, 1'b1, 8'h5A);
      begin
        repeat (16) @(posedge clock);
        #1 ready_mode = 2;
      end
    join
    wait_drain();

    // full aliasing on register 0
    do_issue(5'd0, 5'd0, 5'd0, 1'b0, 8'h77);
    wait_drain();

    // asynchronous reset while READ_VS2 is in progress
    do_issue(5'd1, 5'd2, 5'd6, 1'b0, 8'h11);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    do_issue(5'd7, 5'd8, 5'd9, 1'b0, 8'hC3);
    wait_drain();

    // randomized traffic with random back-pressure and register contents
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    ready_mode = 0;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
      do_issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    ready_mode = 2;
    wait_drain();
    repeat (2) @(posedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_operand_fetch.md
# vector_operand_fetch

Sequential operand-read stage of the vector lane; the counterpart of the vector write-back stage. Accepts one issued vector instruction, reads v0 (mask), vs1, vs2 and vd (old destination) through the single synchronous read port of the vector register file, and presents the assembled operand bundle, tag and masking controls downstream on a valid/ready handshake. The write-back stage consumes these values directly.

## Interface
- DATA_WIDTH, 64, width of one vector register slice.
- TAG_WIDTH, 8, width of the instruction tag carried alongside the data.
- REG_ADDR_WIDTH, 5, vector register index width (32 registers).

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  issue request valid.
- issue_ready  out  1  stage can accept an issue.
- issue_vs1, issue_vs2, issue_vd  in  REG_ADDR_WIDTH each  source and destination register indices.
- issue_vm  in  1  1 = unmasked (v0 not read), 0 = masked.
- issue_tag  in  TAG_WIDTH  instruction tag.
- rf_read_enable  out  1  register-file read strobe.
- rf_read_address  out  REG_ADDR_WIDTH  register-file read index.
- rf_read_data  in  DATA_WIDTH  read data; valid the cycle after rf_read_enable.
- operand_valid  out  1  bundle valid.
- operand_ready  in  1  downstream accepts the bundle.
- v0_data, vs1_data, vs2_data, vd_old_data  out  DATA_WIDTH each  fetched operands.
- operand_tag  out  TAG_WIDTH; operand_vd  out  REG_ADDR_WIDTH; operand_vm  out  1  forwarded from issue.

## Operation
- FSM states: IDLE, READ_V0, READ_VS1, READ_VS2, READ_VD, DRAIN, VALID.
- IDLE: issue_ready=1. On issue_valid, latch vs1/vs2/vd/vm/tag. Go to READ_V0 if vm=0, else READ_VS1.
- READ_V0: enable=1, address=0. Next state: READ_VS1.
- READ_VS1: enable=1, address=vs1. Next state: READ_VS2.
- READ_VS2: enable=1, address=vs2. Next state: READ_VD.
- READ_VD: enable=1, address=vd. Next state: DRAIN.
- DRAIN: enable=0. Next state: VALID.
- VALID: operand_valid=1. On operand_ready, go to IDLE.
- rf_read_enable=0 in IDLE, DRAIN and VALID. rf_read_address=0 when enable=0.
- Capture: a registered destination selector tracks the read issued in the previous cycle. rf_read_data is written into the selected operand register at the end of the following cycle:
  - V0 read → v0_data (DRAIN-relative order: V0 captured in READ_VS1).
  - VS1 → vs1_data, VS2 → vs2_data, VD → vd_old_data (captured in DRAIN).
- vm=1: v0_data is loaded with all ones at issue accept. No V0 read is issued.
- Index aliasing (e.g. vs1=vs2=vd=0) is legal. Each read is performed independently and returns register contents.
- operand_tag, operand_vd and operand_vm are registered from the issue latch at accept.
- All operand outputs hold stable from the first cycle of VALID until the handshake completes.

## Timing
- Reset (asynchronous, immediate): state=IDLE; all data, tag, vd and vm outputs 0; rf_read_enable=0; rf_read_address=0; operand_valid=0; issue_ready=1.
- issue_ready and operand_valid are decoded from state only. There is no combinational path from issue_valid or operand_ready.
- Accept at edge E0, vm=0: READ_V0 in cycle 1, reads in cycles 1–4, DRAIN in cycle 5, operand_valid=1 from cycle 6. Latency is 6 cycles.
- vm=1: operand_valid=1 from cycle 5. Latency is 5 cycles.
- Back-pressure: VALID persists indefinitely while operand_ready=0. issue_ready=0 throughout.
- No overlap: the earliest next accept is the cycle after the VALID handshake. Minimum issue interval is 7 cycles (vm=0) or 6 cycles (vm=1).
- issue_valid is ignored outside IDLE.
- Reset mid-fetch or mid-VALID: the bundle is discarded. The first post-reset accept behaves identically to the first accept after power-up.

## Test plan
- Reset check: assert reset_n=0 mid-cycle → all outputs reach their reset values immediately, including issue_ready=1.
- Masked fetch: RF model returns 64'h1000_0000_0000_00NN for register NN. Issue vs1=3, vs2=4, vd=5, vm=0, tag=8'hA5.
  - rf_read_address sequence is 0, 3, 4, 5.
  - Cycle 6: operand_valid=1, v0=...00, vs1=...03, vs2=...04, vd_old=...05, tag=A5.
- Unmasked fetch: same stimulus with vm=1 → address sequence 3, 4, 5. v0_data=64'hFFFF_FFFF_FFFF_FFFF. operand_valid in cycle 5.
- Back-pressure: hold operand_ready=0 for 10 cycles after VALID, with issue_valid=1 throughout.
  - Outputs stay constant and issue_ready=0.
  - The second issue is accepted only in the cycle after operand_ready=1.
- Aliasing: vs1=vs2=vd=0, vm=0 → four reads of address 0. All operands equal the register-0 contents.
- Reset during READ_VS2 → state returns to IDLE. A following fetch of vs1=7, vs2=8, vd=9 returns correct data with correct 6-cycle latency.
